// File: rtl/uart_apb_pkg.sv
// Shared constants for the UART16550 APB console master: register map,
// LSR bit positions and the master's FSM/bus-phase encodings.
package uart_apb_pkg;

    localparam logic [2:0] OFF_RBR_THR = 3'd0;
    localparam logic [2:0] OFF_DLL     = 3'd0;
    localparam logic [2:0] OFF_IER_DLM = 3'd1;
    localparam logic [2:0] OFF_FCR     = 3'd2;
    localparam logic [2:0] OFF_LCR     = 3'd3;
    localparam logic [2:0] OFF_LSR     = 3'd5;

    localparam int LSR_DR   = 0;
    localparam int LSR_THRE = 5;

    localparam logic [7:0] LCR_DLAB = 8'h80;

    typedef logic [2:0] state_t;
    localparam state_t ST_INIT   = 3'd0;
    localparam state_t ST_IDLE   = 3'd1;
    localparam state_t ST_LSR_RD = 3'd2;
    localparam state_t ST_RBR_RD = 3'd3;
    localparam state_t ST_THR_WR = 3'd4;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_ACCESS = 2'd2
    } phase_t;

endpackage

// File: rtl/uart_apb_console_master_fifo.sv
// Small synchronous FIFO buffering console bytes until the UART has room.
module byte_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers rely on DEPTH being a power of two to wrap naturally.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_apb_console_master.sv
// APB master that initialises a UART16550 and then polls LSR to move bytes
// between a local TX FIFO, THR, RBR and a valid/ready RX stream.
module uart_apb_console_master
    import uart_apb_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h1000_0000,
    parameter logic [15:0] DIVISOR   = 16'd1,
    parameter logic [7:0]  LCR_VAL   = 8'h03,
    parameter logic [7:0]  FCR_VAL   = 8'h07,
    parameter int          TX_DEPTH  = 16,
    parameter int          BURST_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [7:0]  tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [7:0]  rx_data,
    output logic        init_done,
    output logic        err,
    output logic        out_psel,
    output logic        out_penable,
    output logic [2:0]  out_pprot,
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    state_t        state, nxt_state;
    phase_t        phase, nxt_phase;
    logic [2:0]    init_step, init_step_n;
    logic [CW-1:0] burst, fifo_count;
    logic          run;
    logic [31:0]   paddr_q, pwdata_q;
    logic [3:0]    pstrb_q;
    logic          pwrite_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [7:0]    fifo_head, rd_byte, nxt_byte;
    logic          launch, nxt_write, rx_load, init_fin, burst_load, done;
    logic [2:0]    nxt_off;
    logic [31:0]   nxt_addr;

    function automatic logic [2:0] init_off(input logic [2:0] step);
        case (step)
            3'd0:    return OFF_LCR;
            3'd1:    return OFF_DLL;
            3'd2:    return OFF_IER_DLM;
            3'd3:    return OFF_LCR;
            default: return OFF_FCR;
        endcase
    endfunction

    function automatic logic [7:0] init_byte(input logic [2:0] step);
        case (step)
            3'd0:    return LCR_DLAB | LCR_VAL;
            3'd1:    return DIVISOR[7:0];
            3'd2:    return DIVISOR[15:8];
            3'd3:    return LCR_VAL;
            default: return FCR_VAL;
        endcase
    endfunction

    byte_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tx_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready    = run && !fifo_full;
    assign push        = tx_valid && tx_ready;
    assign init_step_n = init_step + 3'd1;
    assign done        = (phase == PH_ACCESS) && out_pready;
    assign rd_byte     = 8'(out_prdata >> {paddr_q[1:0], 3'b000});
    assign nxt_addr    = UART_BASE + {29'd0, nxt_off};

    assign out_psel    = (phase != PH_IDLE);
    assign out_penable = (phase == PH_ACCESS);
    assign out_pprot   = 3'b000;
    assign out_paddr   = paddr_q;
    assign out_pwrite  = pwrite_q;
    assign out_pstrb   = pstrb_q;
    // THR data comes straight from the FIFO head, which only moves on a completion.
    assign out_pwdata  = (state == ST_THR_WR) ? {4{fifo_head}} : pwdata_q;

    always_comb begin
        launch     = 1'b0;
        nxt_state  = state;
        nxt_off    = OFF_LSR;
        nxt_write  = 1'b0;
        nxt_byte   = 8'h00;
        pop        = 1'b0;
        rx_load    = 1'b0;
        init_fin   = 1'b0;
        burst_load = 1'b0;
        if (phase == PH_IDLE) begin
            if (state == ST_INIT) begin
                launch    = 1'b1;
                nxt_write = 1'b1;
                nxt_off   = init_off(init_step);
                nxt_byte  = init_byte(init_step);
            end else if (state == ST_IDLE && (!rx_valid || !fifo_empty)) begin
                launch    = 1'b1;
                nxt_state = ST_LSR_RD;
            end
        end else if (done) begin
            case (state)
                ST_INIT: begin
                    if (init_step == 3'd4) begin
                        init_fin  = 1'b1;
                        nxt_state = ST_IDLE;
                    end else begin
                        launch    = 1'b1;
                        nxt_write = 1'b1;
                        nxt_off   = init_off(init_step_n);
                        nxt_byte  = init_byte(init_step_n);
                    end
                end
                ST_LSR_RD: begin
                    // A waiting received byte always wins over transmit.
                    if (rd_byte[LSR_DR] && !rx_valid) begin
                        launch    = 1'b1;
                        nxt_off   = OFF_RBR_THR;
                        nxt_state = ST_RBR_RD;
                    end else if (rd_byte[LSR_THRE] && !fifo_empty) begin
                        launch     = 1'b1;
                        nxt_write  = 1'b1;
                        nxt_off    = OFF_RBR_THR;
                        nxt_state  = ST_THR_WR;
                        burst_load = 1'b1;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end
                ST_RBR_RD: begin
                    rx_load   = 1'b1;
                    nxt_state = ST_IDLE;
                end
                ST_THR_WR: begin
                    pop = 1'b1;
                    if (burst == CW'(1)) begin
                        nxt_state = ST_IDLE;
                    end else begin
                        launch    = 1'b1;
                        nxt_write = 1'b1;
                        nxt_off   = OFF_RBR_THR;
                    end
                end
                default: nxt_state = ST_IDLE;
            endcase
        end

        if (launch)                                 nxt_phase = PH_SETUP;
        else if (phase == PH_SETUP)                 nxt_phase = PH_ACCESS;
        else if (phase == PH_ACCESS && !out_pready) nxt_phase = PH_ACCESS;
        else                                        nxt_phase = PH_IDLE;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= ST_INIT;
            phase     <= PH_IDLE;
            init_step <= 3'd0;
            burst     <= '0;
            run       <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pwrite_q  <= 1'b0;
            rx_valid  <= 1'b0;
            rx_data   <= 8'h00;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            run   <= 1'b1;
            state <= nxt_state;
            phase <= nxt_phase;
            if (launch) begin
                paddr_q  <= nxt_addr;
                pwrite_q <= nxt_write;
                pwdata_q <= {4{nxt_byte}};
                pstrb_q  <= nxt_write ? (4'b0001 << nxt_addr[1:0]) : 4'b0000;
            end
            if (done && state == ST_INIT) init_step <= init_step_n;
            if (init_fin)                 init_done <= 1'b1;
            if (done && out_pslverr)      err <= 1'b1;
            if (burst_load)
                burst <= (int'(fifo_count) > BURST_MAX) ? CW'(BURST_MAX) : fifo_count;
            else if (pop)
                burst <= burst - CW'(1);
            if (rx_load) begin
                rx_valid <= 1'b1;
                rx_data  <= rd_byte;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_apb_console_master.sv
// Directed bench: APB slave model with LSR/RBR values, wait states and
// pslverr injection, plus a completion log used for ordering checks.
module tb_uart_apb_console_master;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, init_done, err;
    logic [7:0]  tx_data, rx_data;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic [2:0]  out_pprot;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic [3:0]  out_pstrb;

    always #5 clock = ~clock;

    uart_apb_console_master dut (
        .clock       (clock),
        .reset       (reset),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .init_done   (init_done),
        .err         (err),
        .out_psel    (out_psel),
        .out_penable (out_penable),
        .out_pprot   (out_pprot),
        .out_paddr   (out_paddr),
        .out_pwrite  (out_pwrite),
        .out_pwdata  (out_pwdata),
        .out_pstrb   (out_pstrb),
        .out_pready  (out_pready),
        .out_prdata  (out_prdata),
        .out_pslverr (out_pslverr)
    );

    // Slave model
    logic [7:0]  lsr_val = 8'h00;
    logic [7:0]  rbr_val = 8'h00;
    int          waits = 0;
    int          wcnt = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [7:0]  rd_val;

    assign out_pready  = out_penable && (wcnt >= waits);
    assign out_pslverr = err_en && (out_paddr == err_addr);
    assign rd_val      = (out_paddr[2:0] == 3'd5) ? lsr_val : rbr_val;
    assign out_prdata  = {24'h0, rd_val} << (8 * out_paddr[1:0]);

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          acc;
    } xfer_t;

    xfer_t       log_q[$];
    logic [31:0] snap_addr, snap_wdata;
    logic [3:0]  snap_strb;
    logic        snap_wr;
    int          acc_cnt = 0;
    int          unstable = 0;
    xfer_t       mon_e;

    always @(posedge clock) begin
        if (out_psel && out_penable && !out_pready) wcnt <= wcnt + 1;
        else                                        wcnt <= 0;
        if (out_psel && !out_penable) begin
            snap_addr  <= out_paddr;
            snap_wdata <= out_pwdata;
            snap_strb  <= out_pstrb;
            snap_wr    <= out_pwrite;
            acc_cnt    <= 0;
        end
        if (out_psel && out_penable) begin
            if (out_paddr !== snap_addr || out_pwdata !== snap_wdata ||
                out_pstrb !== snap_strb || out_pwrite !== snap_wr)
                unstable <= unstable + 1;
            acc_cnt <= acc_cnt + 1;
            if (out_pready) begin
                mon_e = '{out_paddr, out_pwrite, out_pwdata, out_pstrb, acc_cnt + 1};
                log_q.push_back(mon_e);
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic xfer_t ent(input int i);
        xfer_t z;
        z = '{32'hFFFF_FFFF, 1'b0, 32'h0, 4'h0, 0};
        if (i >= 0 && i < log_q.size()) z = log_q[i];
        return z;
    endfunction

    function automatic int count_writes();
        int c = 0;
        foreach (log_q[i]) if (log_q[i].wr) c++;
        return c;
    endfunction

    function automatic int count_reads_at(input logic [31:0] a);
        int c = 0;
        foreach (log_q[i]) if (!log_q[i].wr && log_q[i].addr == a) c++;
        return c;
    endfunction

    task automatic push(input logic [7:0] b);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (k >= 200) chk("push_timeout", 32'(k), 32'd0);
        @(negedge clock);
        tx_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] exp_addr [5] = '{32'h1000_0003, 32'h1000_0000, 32'h1000_0001, 32'h1000_0003, 32'h1000_0002};
    logic [31:0] exp_data [5] = '{32'h8383_8383, 32'h0101_0101, 32'h0000_0000, 32'h0303_0303, 32'h0707_0707};
    logic [3:0]  exp_strb [5] = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0100};

    initial begin
        int    n;
        int    cur;
        int    widx;
        int    runs[$];
        xfer_t e;
        logic [7:0] b;

        tx_valid = 1'b0;
        tx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) @(negedge clock);

        chk("rst_psel", 32'(out_psel), 0);
        chk("rst_penable", 32'(out_penable), 0);
        chk("rst_paddr", out_paddr, 0);
        chk("rst_pwdata", out_pwdata, 0);
        chk("rst_pstrb", 32'(out_pstrb), 0);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_err", 32'(err), 0);

        // Init sequence, zero-wait slave
        log_q.delete();
        reset = 1'b1;
        n = 0;
        while (!init_done && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("init_cycles", 32'(n), 32'd11);
        for (int i = 0; i < 5; i++) begin
            e = ent(i);
            chk("init_addr", e.addr, exp_addr[i]);
            chk("init_wr", 32'(e.wr), 1);
            chk("init_wdata", e.wdata, exp_data[i]);
            chk("init_strb", 32'(e.strb), 32'(exp_strb[i]));
        end
        chk("init_err", 32'(err), 0);

        // Three bytes, one LSR read then a 3-write burst
        lsr_val = 8'h00;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        lsr_val = 8'h60;
        log_q.delete();
        repeat (30) @(negedge clock);
        e = ent(0);
        chk("tx3_lsr_addr", e.addr, BASE + 32'd5);
        chk("tx3_lsr_rd", 32'(e.wr), 0);
        for (int i = 0; i < 3; i++) begin
            e = ent(1 + i);
            b = 8'h41 + 8'(i);
            chk("tx3_addr", e.addr, BASE);
            chk("tx3_wr", 32'(e.wr), 1);
            chk("tx3_wdata", e.wdata, {4{b}});
            chk("tx3_strb", 32'(e.strb), 32'h1);
        end
        chk("tx3_writes", 32'(count_writes()), 3);
        chk("tx3_ready", 32'(tx_ready), 1);

        // Twenty bytes: fill to full, then bursts of 16 and 4
        lsr_val = 8'h00;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        chk("full_tx_ready", 32'(tx_ready), 0);
        lsr_val = 8'h60;
        log_q.delete();
        for (int i = 16; i < 20; i++) push(8'h10 + 8'(i));
        repeat (80) @(negedge clock);
        cur = 0;
        widx = 0;
        foreach (log_q[i]) begin
            if (log_q[i].wr && log_q[i].addr == BASE) begin
                cur++;
                b = 8'h10 + 8'(widx);
                chk("burst_data", log_q[i].wdata, {4{b}});
                widx++;
            end else if (cur > 0) begin
                runs.push_back(cur);
                cur = 0;
            end
        end
        if (cur > 0) runs.push_back(cur);
        chk("burst_runs", 32'(runs.size()), 2);
        chk("burst_run0", (runs.size() > 0) ? 32'(runs[0]) : 32'hFFFF_FFFF, 16);
        chk("burst_run1", (runs.size() > 1) ? 32'(runs[1]) : 32'hFFFF_FFFF, 4);
        chk("burst_total", 32'(widx), 20);

        // Receive with consumer stalled
        lsr_val = 8'h00;
        repeat (5) @(negedge clock);
        rbr_val = 8'h5A;
        lsr_val = 8'h01;
        log_q.delete();
        repeat (20) @(negedge clock);
        chk("rx_valid", 32'(rx_valid), 1);
        chk("rx_data", 32'(rx_data), 32'h5A);
        chk("rx_rbr_reads", 32'(count_reads_at(BASE)), 1);
        chk("rx_log_size", 32'(log_q.size()), 2);
        repeat (10) @(negedge clock);
        chk("rx_stall_reads", 32'(count_reads_at(BASE)), 1);
        chk("rx_stall_data", 32'(rx_data), 32'h5A);
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;
        chk("rx_accept", 32'(rx_valid), 0);
        rbr_val = 8'h5B;
        repeat (10) @(negedge clock);
        chk("rx2_valid", 32'(rx_valid), 1);
        chk("rx2_data", 32'(rx_data), 32'h5B);
        chk("rx2_rbr_reads", 32'(count_reads_at(BASE)), 2);
        lsr_val = 8'h00;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;

        // DR and THRE together: RX first, TX on the next poll
        push(8'h77);
        rbr_val = 8'hA5;
        lsr_val = 8'h61;
        log_q.delete();
        repeat (20) @(negedge clock);
        chk("prio_log_size", 32'(log_q.size()), 4);
        chk("prio_e0_addr", ent(0).addr, BASE + 32'd5);
        chk("prio_e1_addr", ent(1).addr, BASE);
        chk("prio_e1_wr", 32'(ent(1).wr), 0);
        chk("prio_e2_addr", ent(2).addr, BASE + 32'd5);
        chk("prio_e3_wr", 32'(ent(3).wr), 1);
        chk("prio_e3_wdata", ent(3).wdata, 32'h7777_7777);
        chk("prio_rx_data", 32'(rx_data), 32'hA5);
        lsr_val = 8'h00;
        rx_ready = 1'b1;
        @(negedge clock);
        rx_ready = 1'b0;

        // Re-init with 3 wait states and an error on the DLM write
        reset = 1'b0;
        repeat (2) @(negedge clock);
        waits    = 3;
        err_en   = 1'b1;
        err_addr = BASE + 32'd1;
        log_q.delete();
        reset = 1'b1;
        n = 0;
        while (!init_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("wait_init_cycles", 32'(n), 32'd26);
        chk("wait_dlm_addr", ent(2).addr, BASE + 32'd1);
        chk("wait_dlm_acc", 32'(ent(2).acc), 4);
        chk("wait_fcr_addr", ent(4).addr, BASE + 32'd2);
        chk("wait_err", 32'(err), 1);
        err_en = 1'b0;
        waits  = 0;
        repeat (20) @(negedge clock);
        chk("err_sticky", 32'(err), 1);

        // Reset in the middle of a THR burst
        lsr_val = 8'h00;
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        lsr_val = 8'h60;
        n = 0;
        while (!(out_psel && out_pwrite && out_paddr == BASE) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("midburst_seen", 32'(n < 50), 1);
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_psel", 32'(out_psel), 0);
        chk("midrst_penable", 32'(out_penable), 0);
        chk("midrst_pstrb", 32'(out_pstrb), 0);
        chk("midrst_tx_ready", 32'(tx_ready), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        @(negedge clock);
        log_q.delete();
        reset = 1'b1;
        repeat (40) @(negedge clock);
        chk("midrst_init_again", 32'(init_done), 1);
        chk("midrst_fifo_empty", 32'(count_writes()), 5);
        chk("stable_access", 32'(unstable), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
